// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
//   Upstream feeder for a 4-to-1, 2-bit mux stage.
//
//   - Captures four 2-bit channels from an 8-bit switch bank on the rising
//     edge of the load request.
//   - Drives the mux select either manually from sel_man or by auto-scanning
//     0 -> 1 -> 2 -> 3 -> 0, spending PERIOD clock cycles in each slot.
//   - Emits registered slot_tick / wrap pulses for downstream display logic.
//
// Optional build macro:
//   MUX_SCAN_SYNC_EN - places a 2-flop synchronizer on every input except
//                      clk/rst_n. All input-to-output latencies grow by 2.
//
// Ports:
//   clk            system clock, all state on its rising edge
//   rst_n          asynchronous active-low reset
//   sw[7:0]        channel data: [1:0]->a0 [3:2]->a1 [5:4]->a2 [7:6]->a3
//   load           load request level (acted on at its rising edge only)
//   mode           0 = manual select, 1 = auto scan
//   hold           auto mode only: freezes the slot counter and s
//   sel_man[1:0]   manual select value
//   a0..a3[1:0]    registered channel data to the mux
//   s[1:0]         registered select to the mux
//   slot_tick      one-cycle pulse in the cycle after s changed value
//   wrap           one-cycle pulse alongside slot_tick for an auto 3->0 step
module mux_sel_scanner #(
  parameter int PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       load,
  input  logic       mode,
  input  logic       hold,
  input  logic [1:0] sel_man,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] s,
  output logic       slot_tick,
  output logic       wrap
);

  // PERIOD = 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       w_sw;
  logic             w_load;
  logic             w_mode;
  logic             w_hold;
  logic [1:0]       w_sel_man;

  logic             r_load_q;
  logic [1:0]       r_a0, r_a1, r_a2, r_a3;
  logic [1:0]       r_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_slot_tick;
  logic             r_wrap;

  logic             w_load_edge;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_s_nxt;
  logic             w_adv;

`ifdef MUX_SCAN_SYNC_EN
  // Bundle order: {sel_man, hold, mode, load, sw}
  logic [12:0] r_sync1;
  logic [12:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sel_man, hold, mode, load, sw};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_sel_man, w_hold, w_mode, w_load, w_sw} = r_sync2;
`else
  assign w_sw      = sw;
  assign w_load    = load;
  assign w_mode    = mode;
  assign w_hold    = hold;
  assign w_sel_man = sel_man;
`endif

  assign w_load_edge = w_load & ~r_load_q;

  // Select/counter next state. Manual mode keeps the counter at 0 so that a
  // switch into auto mode always spends a full PERIOD in the current slot.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_s_nxt   = r_s;
    w_adv     = 1'b0;
    if (!w_mode) begin
      w_cnt_nxt = '0;
      w_s_nxt   = w_sel_man;
    end else if (!w_hold) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt = '0;
        w_s_nxt   = r_s + 2'd1;
        w_adv     = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_q    <= 1'b0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_a3        <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_slot_tick <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_load_q <= w_load;
      // Capture is independent of the select logic; both may act on one edge.
      if (w_load_edge) begin
        r_a0 <= w_sw[1:0];
        r_a1 <= w_sw[3:2];
        r_a2 <= w_sw[5:4];
        r_a3 <= w_sw[7:6];
      end
      r_cnt       <= w_cnt_nxt;
      r_s         <= w_s_nxt;
      // Any value change pulses slot_tick, including manual ones; wrap only
      // flags the auto-driven 3 -> 0 roll-over.
      r_slot_tick <= (w_s_nxt != r_s);
      r_wrap      <= w_adv & (r_s == 2'd3);
    end
  end

  assign a0        = r_a0;
  assign a1        = r_a1;
  assign a2        = r_a2;
  assign a3        = r_a3;
  assign s         = r_s;
  assign slot_tick = r_slot_tick;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner: two instances (PERIOD = 4 and PERIOD = 1) share
// the same stimulus and are compared every cycle against a slot-level model.
module tb_mux_sel_scanner;

`ifdef MUX_SCAN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [7:0] sw;
    logic       load;
    logic       mode;
    logic       hold;
    logic [1:0] sel;
  } in_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       load;
  logic       mode;
  logic       hold;
  logic [1:0] sel_man;

  logic [1:0] o_a0 [2];
  logic [1:0] o_a1 [2];
  logic [1:0] o_a2 [2];
  logic [1:0] o_a3 [2];
  logic [1:0] o_s  [2];
  logic       o_tick [2];
  logic       o_wrap [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int  per [2] = '{4, 1};
  int  m_a [4];
  int  m_lprev;
  int  m_s [2];
  int  m_el [2];     // cycles already spent in the current auto slot
  int  m_tick [2];
  int  m_wrap [2];
  in_t pipe [$];     // models input synchronization delay (LAT edges)

  mux_sel_scanner #(.PERIOD(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .mode(mode),
    .hold(hold), .sel_man(sel_man),
    .a0(o_a0[0]), .a1(o_a1[0]), .a2(o_a2[0]), .a3(o_a3[0]),
    .s(o_s[0]), .slot_tick(o_tick[0]), .wrap(o_wrap[0])
  );

  mux_sel_scanner #(.PERIOD(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .load(load), .mode(mode),
    .hold(hold), .sel_man(sel_man),
    .a0(o_a0[1]), .a1(o_a1[1]), .a2(o_a2[1]), .a3(o_a3[1]),
    .s(o_s[1]), .slot_tick(o_tick[1]), .wrap(o_wrap[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bound(input string tag, input bit found);
    n_cmp++;
    assert (found) else begin
      n_bad++;
      $error("FAIL %s: observed timeout expected event", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_a[i] = 0;
    m_lprev = 0;
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 0; m_el[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end
    pipe.delete();
  endtask

  // One rising clock edge of the intended behaviour.
  task automatic model_edge();
    in_t cur;
    in_t e;
    int  old_s;
    int  new_s;
    bit  adv;
    cur = {sw, load, mode, hold, sel_man};
    pipe.push_back(cur);
    if (pipe.size() > LAT) e = pipe.pop_front();
    else e = '0;
    if (e.load && m_lprev == 0)
      for (int i = 0; i < 4; i++) m_a[i] = (int'(e.sw) >> (2 * i)) % 4;
    m_lprev = e.load ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      old_s = m_s[k];
      new_s = old_s;
      adv   = 1'b0;
      if (!e.mode) begin
        m_el[k] = 0;
        new_s   = int'(e.sel);
      end else if (!e.hold) begin
        m_el[k]++;
        if (m_el[k] == per[k]) begin
          m_el[k] = 0;
          new_s   = (old_s + 1) % 4;
          adv     = 1'b1;
        end
      end
      m_tick[k] = (new_s != old_s) ? 1 : 0;
      m_wrap[k] = (adv && old_s == 3) ? 1 : 0;
      m_s[k]    = new_s;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_a;
    exp_a = m_a[0] + 4 * m_a[1] + 16 * m_a[2] + 64 * m_a[3];
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/P%0d_a", tag, per[k]),
          {24'd0, o_a3[k], o_a2[k], o_a1[k], o_a0[k]}, exp_a);
      chk($sformatf("%s/P%0d_s", tag, per[k]), {30'd0, o_s[k]}, m_s[k]);
      chk($sformatf("%s/P%0d_tick", tag, per[k]), {31'd0, o_tick[k]}, m_tick[k]);
      chk($sformatf("%s/P%0d_wrap", tag, per[k]), {31'd0, o_wrap[k]}, m_wrap[k]);
    end
  endtask

  // Advance one clock; inputs are stable at the edge, outputs read at negedge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; sw = 8'h00; load = 1'b0; mode = 1'b0; hold = 1'b0; sel_man = 2'd0;
    model_reset();
    #1;
    check_all("reset");
    repeat (3) tick("in_reset");
    rst_n = 1'b1;

    // Put non-zero data on the channels so the reset check is meaningful.
    sw = 8'hB1; load = 1'b1;
    repeat (LAT + 1) tick("preload");
    load = 1'b0;
    tick("preload_lo");

    // Auto scan until s = 2 on the PERIOD = 4 instance, then reset mid-scan.
    mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick("scan_to2");
      if (m_s[0] == 2) found = 1'b1;
    end
    chk_bound("reach_s2", found);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) tick("held_rst");
    rst_n = 1'b1;

    // Auto scan from reset: 0,1,2,3,0 with tick/wrap pulses.
    repeat (24) tick("auto");

    // Load held high for several cycles, then sw changes with load still high.
    sw = 8'b11_10_01_00; load = 1'b1;
    repeat (5) tick("load_hi");
    sw = 8'hFF;
    repeat (3) tick("load_ff");
    load = 1'b0;
    repeat (2) tick("load_lo");

    // Hold at counter = 2 with s = 1.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick("seek_hold");
      if (m_s[0] == 1 && m_el[0] == 2) found = 1'b1;
    end
    chk_bound("reach_hold_pt", found);
    hold = 1'b1;
    repeat (10) tick("hold");
    hold = 1'b0;
    repeat (6) tick("hold_rel");

    // Manual select and mode switches.
    mode = 1'b0; sel_man = 2'd3;
    repeat (2 + LAT) tick("man3");
    sel_man = 2'd0;
    repeat (2 + LAT) tick("man0");
    mode = 1'b1;
    repeat (10) tick("man2auto");

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      sw      = 8'($urandom);
      load    = ($urandom_range(0, 3) == 0);
      mode    = ($urandom_range(0, 7) != 0);
      hold    = ($urandom_range(0, 5) == 0);
      sel_man = 2'($urandom);
      tick("rand");
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        tick("rand_in_rst");
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
